// File: rtl/sdram_tester.sv
// Bus-master pattern tester for the SDRAM controller host port.
// Fills an address range with a pattern, or reads it back and counts mismatches.
module sdram_tester #(
   parameter int ACCESS_CYCLES = 8,
   parameter int RD_LATENCY    = 6
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [2:0]  Addr,
   input  logic [15:0] DataWr,
   output logic [15:0] DataRd,
   input  logic        En,
   input  logic        Rd,
   input  logic        Wr,
   output logic [22:0] MAddr,
   output logic [15:0] MDataWr,
   input  logic [15:0] MDataRd,
   output logic        MEn,
   output logic        MRd,
   output logic        MWr,
   output logic        MIdle,
   output logic        Busy
);

   localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] WLOAD  = CW'(ACCESS_CYCLES - 2);
   localparam logic [CW-1:0] SAMPLE = CW'(ACCESS_CYCLES - 1 - RD_LATENCY);

   typedef enum logic [1:0] {IDLE, SETUP, ISSUE, WAIT} state_t;

   state_t        state, state_n;
   logic [15:0]   addr_lo;
   logic [6:0]    addr_hi;
   logic [15:0]   count;
   logic [15:0]   seed;
   logic          mode, inc;
   logic          done, error, aborted, abort_pend;
   logic [15:0]   errcnt, erraddr, errdata;
   logic [22:0]   waddr;
   logic [15:0]   remain;
   logic [15:0]   pat;
   logic [CW-1:0] wcnt;
   logic [15:0]   rdata;

   logic busy, wr_en, ctrl_wr, start, abort_req, last;

   assign busy      = (state != IDLE);
   assign wr_en     = En & Wr;
   assign ctrl_wr   = wr_en && (Addr == 3'd4);
   assign start     = ctrl_wr && DataWr[0] && !busy;
   assign abort_req = ctrl_wr && DataWr[3] && busy;
   assign last      = (remain == 16'd1) || abort_pend || abort_req;

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_n;
   end

   // SETUP gives the loaded working registers one cycle before the first strobe
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = SETUP;
         SETUP:   state_n = ISSUE;
         ISSUE:   state_n = WAIT;
         WAIT:    if (wcnt == '0) state_n = last ? IDLE : ISSUE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         addr_lo    <= '0;
         addr_hi    <= '0;
         count      <= '0;
         seed       <= '0;
         mode       <= 1'b0;
         inc        <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         aborted    <= 1'b0;
         abort_pend <= 1'b0;
         errcnt     <= '0;
         erraddr    <= '0;
         errdata    <= '0;
         waddr      <= '0;
         remain     <= '0;
         pat        <= '0;
         wcnt       <= '0;
      end else begin
         if (wr_en && !busy) begin
            case (Addr)
               3'd0:    addr_lo <= DataWr;
               3'd1:    addr_hi <= DataWr[6:0];
               3'd2:    count   <= DataWr;
               3'd3:    seed    <= DataWr;
               default: ;
            endcase
         end
         if (start) begin
            mode       <= DataWr[1];
            inc        <= DataWr[2];
            done       <= 1'b0;
            error      <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            errcnt     <= '0;
            erraddr    <= '0;
            errdata    <= '0;
            waddr      <= {addr_hi, addr_lo};
            remain     <= count;
            pat        <= seed;
         end
         if (abort_req) abort_pend <= 1'b1;
         if (state == ISSUE) wcnt <= WLOAD;
         if (state == WAIT) begin
            wcnt <= wcnt - 1'b1;
            if (mode && wcnt == SAMPLE && MDataRd != pat) begin
               if (errcnt != 16'hFFFF) errcnt <= errcnt + 16'd1;
               error <= 1'b1;
               if (!error) begin
                  erraddr <= waddr[15:0];
                  errdata <= MDataRd;
               end
            end
            if (wcnt == '0) begin
               waddr  <= waddr + 23'd1;
               pat    <= inc ? pat + 16'd1 : pat;
               remain <= remain - 16'd1;
               if (last) begin
                  done       <= 1'b1;
                  aborted    <= abort_pend | abort_req;
                  abort_pend <= 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (Addr)
         3'd0:    rdata = addr_lo;
         3'd1:    rdata = {9'd0, addr_hi};
         3'd2:    rdata = count;
         3'd3:    rdata = seed;
         3'd4:    rdata = {10'd0, inc, mode, aborted, error, done, busy};
         3'd5:    rdata = errcnt;
         3'd6:    rdata = erraddr;
         default: rdata = errdata;
      endcase
   end

   assign DataRd  = (En && Rd) ? rdata : 16'd0;
   assign MAddr   = waddr;
   assign MDataWr = pat;
   assign MEn     = busy;
   assign MRd     = (state == ISSUE) && mode;
   assign MWr     = (state == ISSUE) && !mode;
   assign MIdle   = (state == IDLE);
   assign Busy    = busy;

endmodule

// File: tb/tb_sdram_tester.sv
// Directed bench for sdram_tester: fill, check, wrap, abort and reset cases
// against a small memory model with a fixed read latency.
module tb_sdram_tester;

   localparam int RDL = 6;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [2:0]  Addr;
   logic [15:0] DataWr;
   logic [15:0] DataRd;
   logic        En, Rd, Wr;
   logic [22:0] MAddr;
   logic [15:0] MDataWr;
   logic [15:0] MDataRd;
   logic        MEn, MRd, MWr, MIdle, Busy;

   sdram_tester dut (
      .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataWr(DataWr),
      .DataRd(DataRd), .En(En), .Rd(Rd), .Wr(Wr),
      .MAddr(MAddr), .MDataWr(MDataWr), .MDataRd(MDataRd),
      .MEn(MEn), .MRd(MRd), .MWr(MWr), .MIdle(MIdle), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;

   logic [15:0] mem [int];
   int          str_k[$];
   logic [22:0] str_a[$];
   logic [15:0] str_d[$];
   int          n_rd, n_wr, done_k;
   int          sk[$];
   logic [2:0]  sa[$];
   logic [15:0] sd[$];
   logic [15:0] rv;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic hwr(input logic [2:0] a, input logic [15:0] d);
      @(negedge Clk);
      Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
      @(posedge Clk);
      #1;
      En = 1'b0; Wr = 1'b0;
   endtask

   task automatic hrd(input logic [2:0] a, output logic [15:0] d);
      @(negedge Clk);
      Addr = a; En = 1'b1; Rd = 1'b1;
      #1;
      d = DataRd;
      En = 1'b0; Rd = 1'b0;
   endtask

   task automatic sched(input int k, input logic [2:0] a, input logic [15:0] d);
      sk.push_back(k); sa.push_back(a); sd.push_back(d);
   endtask

   // k counts rising edges after the start write; sampled at the falling edge
   task automatic capture(input int maxc);
      int rd_k;
      logic [22:0] rd_a;
      rd_k = -100;
      rd_a = '0;
      str_k.delete(); str_a.delete(); str_d.delete();
      n_rd = 0; n_wr = 0; done_k = -1;
      for (int k = 1; k <= maxc; k++) begin
         @(posedge Clk);
         @(negedge Clk);
         En = 1'b0; Wr = 1'b0;
         if (!Busy) begin
            done_k = k;
            break;
         end
         foreach (sk[i]) begin
            if (sk[i] == k) begin
               Addr = sa[i]; DataWr = sd[i]; En = 1'b1; Wr = 1'b1;
            end
         end
         if (MWr || MRd) begin
            str_k.push_back(k); str_a.push_back(MAddr); str_d.push_back(MDataWr);
         end
         if (MWr) begin
            n_wr++;
            mem[int'(MAddr)] = MDataWr;
         end
         if (MRd) begin
            n_rd++;
            rd_k = k;
            rd_a = MAddr;
         end
         if (k == rd_k + RDL)
            MDataRd = mem.exists(int'(rd_a)) ? mem[int'(rd_a)] : 16'h0000;
         else
            MDataRd = 16'hDEAD;
      end
      sk.delete(); sa.delete(); sd.delete();
      En = 1'b0; Wr = 1'b0;
      chk("capture_done", {31'd0, done_k > 0}, 32'd1);
   endtask

   initial begin
      Reset = 1'b1; Addr = '0; DataWr = '0; En = 1'b0; Rd = 1'b0; Wr = 1'b0;
      MDataRd = 16'hDEAD;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      chk("rst_midle", MIdle, 1);
      chk("rst_men", MEn, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_strobes", {MRd, MWr}, 0);
      chk("rst_maddr", MAddr, 0);
      hrd(3'd4, rv); chk("rst_ctrl", rv, 0);

      // fill 4 words, incrementing pattern
      hwr(3'd0, 16'h0010);
      hwr(3'd1, 16'h0000);
      hwr(3'd2, 16'h0004);
      hwr(3'd3, 16'hA000);
      hrd(3'd2, rv); chk("count_rb", rv, 16'h0004);
      @(negedge Clk);
      Addr = 3'd2; En = 1'b0; Rd = 1'b1;
      #1; chk("datard_en_low", DataRd, 0);
      Rd = 1'b0;
      sched(32, 3'd4, 16'h0005);
      hwr(3'd4, 16'h0005);
      capture(60);
      chk("fill_nwr", n_wr, 4);
      chk("fill_nrd", n_rd, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fill_k%0d", i), str_k[i], 1 + 8 * i);
         chk($sformatf("fill_a%0d", i), str_a[i], 23'h10 + i);
         chk($sformatf("fill_d%0d", i), str_d[i], 16'hA000 + i);
      end
      chk("fill_done_k", done_k, 33);
      chk("fill_men_low", MEn, 0);
      chk("fill_midle", MIdle, 1);
      hrd(3'd4, rv); chk("fill_ctrl", rv, 16'h0022);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("late_start_ignored", Busy, 0);

      // check pass
      hwr(3'd4, 16'h0007);
      capture(60);
      chk("chk_nrd", n_rd, 4);
      chk("chk_done_k", done_k, 33);
      hrd(3'd5, rv); chk("chk_errcnt", rv, 0);
      hrd(3'd4, rv); chk("chk_ctrl", rv, 16'h0032);

      // check with corrupted words
      mem[32'h12] = 16'h1234;
      mem[32'h13] = 16'h0000;
      hwr(3'd4, 16'h0007);
      capture(60);
      hrd(3'd5, rv); chk("bad_errcnt", rv, 2);
      hrd(3'd6, rv); chk("bad_erraddr", rv, 16'h0012);
      hrd(3'd7, rv); chk("bad_errdata", rv, 16'h1234);
      hrd(3'd4, rv); chk("bad_ctrl", rv, 16'h0036);

      // address wrap, constant pattern
      hwr(3'd0, 16'hFFFF);
      hwr(3'd1, 16'hFFFF);
      hwr(3'd2, 16'h0002);
      hwr(3'd3, 16'h5555);
      hrd(3'd1, rv); chk("addr_hi_rb", rv, 16'h007F);
      hwr(3'd4, 16'h0001);
      capture(40);
      chk("wrap_n", n_wr, 2);
      chk("wrap_a0", str_a[0], 23'h7FFFFF);
      chk("wrap_a1", str_a[1], 23'h000000);
      chk("wrap_d1", str_d[1], 16'h5555);
      chk("wrap_done_k", done_k, 17);
      hrd(3'd5, rv); chk("wrap_errcnt_clr", rv, 0);

      // abort during third word, busy writes ignored
      hwr(3'd0, 16'h0100);
      hwr(3'd1, 16'h0000);
      hwr(3'd2, 16'd100);
      hwr(3'd3, 16'h00AA);
      sched(3, 3'd0, 16'hFFFF);
      sched(4, 3'd1, 16'hFFFF);
      sched(5, 3'd2, 16'hFFFF);
      sched(6, 3'd3, 16'hFFFF);
      sched(7, 3'd4, 16'h0003);
      sched(20, 3'd4, 16'h0008);
      hwr(3'd4, 16'h0001);
      capture(900);
      chk("abort_nstrobe", str_k.size(), 3);
      chk("abort_nwr", n_wr, 3);
      chk("abort_done_k", done_k, 25);
      hrd(3'd4, rv); chk("abort_ctrl", rv, 16'h000A);
      hrd(3'd0, rv); chk("busy_wr_lo", rv, 16'h0100);
      hrd(3'd1, rv); chk("busy_wr_hi", rv, 16'h0000);
      hrd(3'd2, rv); chk("busy_wr_cnt", rv, 16'd100);
      hrd(3'd3, rv); chk("busy_wr_seed", rv, 16'h00AA);
      hwr(3'd4, 16'h0008);
      hrd(3'd4, rv); chk("idle_abort_ignored", rv, 16'h000A);

      // reset during WAIT
      hwr(3'd0, 16'h0040);
      hwr(3'd3, 16'h1111);
      hwr(3'd2, 16'h0004);
      hwr(3'd4, 16'h0001);
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("pre_rst_busy", Busy, 1);
      Reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      chk("mid_rst_men", MEn, 0);
      chk("mid_rst_midle", MIdle, 1);
      chk("mid_rst_busy", Busy, 0);
      chk("mid_rst_maddr", MAddr, 0);
      chk("mid_rst_mdatawr", MDataWr, 0);
      Reset = 1'b0;
      for (int r = 0; r < 8; r++) begin
         hrd(3'(r), rv);
         chk($sformatf("mid_rst_reg%0d", r), rv, 0);
      end

      // restart after reset
      hwr(3'd0, 16'h0005);
      hwr(3'd2, 16'h0001);
      hwr(3'd3, 16'h0007);
      hwr(3'd4, 16'h0001);
      capture(30);
      chk("restart_n", n_wr, 1);
      chk("restart_k", str_k[0], 1);
      chk("restart_a", str_a[0], 23'h000005);
      chk("restart_d", str_d[0], 16'h0007);
      chk("restart_done_k", done_k, 9);
      hrd(3'd4, rv); chk("restart_ctrl", rv, 16'h0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
